// File: rtl/mem_access.sv
// mem_access: memory stage of the pipeline. Converts EX_MEM load/store
// requests into a single-outstanding req/ack data-memory transaction. It
// formats byte enables and store data, extracts and extends load data, and
// drives the MEM_WB writeback registers.
//
// Ports
//   clk, Rst                 clock; asynchronous active-high reset
//   debug                    freeze: holds IDLE/DONE, does not interrupt BUSY
//   EX_MEM_*                 stage controls, destination, address/ALU result,
//                            store data
//   dmem_req/we/addr/be/wdata  registered memory request (word-aligned addr)
//   dmem_rdata, dmem_ack     memory response
//   mem_stall                freezes upstream stages (combinational)
//   mem_misalign             sticky misaligned-access flag
//   MEM_WB_regwrite/rd/res   writeback registers
module mem_access #(
  parameter int unsigned DMEM_AW = 32
) (
  input  logic               clk,
  input  logic               Rst,
  input  logic               debug,
  input  logic               EX_MEM_memread,
  input  logic               EX_MEM_memwrite,
  input  logic               EX_MEM_regwrite,
  input  logic [4:0]         EX_MEM_loadcntrl,
  input  logic [2:0]         EX_MEM_storecntrl,
  input  logic [4:0]         EX_MEM_rd,
  input  logic [31:0]        EX_MEM_alures,
  input  logic [31:0]        EX_MEM_dout_rs2,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [DMEM_AW-1:0] dmem_addr,
  output logic [3:0]         dmem_be,
  output logic [31:0]        dmem_wdata,
  input  logic [31:0]        dmem_rdata,
  input  logic               dmem_ack,
  output logic               mem_stall,
  output logic               mem_misalign,
  output logic               MEM_WB_regwrite,
  output logic [4:0]         MEM_WB_rd,
  output logic [31:0]        MEM_WB_res
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

  state_t      state;
  size_t       size_c;
  logic        sign_c;
  logic        access_c;
  logic        aligned_c;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;
  logic [1:0]  off_c;

  // Transaction context latched on entry to BUSY
  logic        load_q;
  logic        regwrite_q;
  logic [4:0]  rd_q;
  size_t       size_q;
  logic        sign_q;
  logic [1:0]  off_q;
  logic [31:0] rdata_q;

  logic [7:0]  byte_c;
  logic [15:0] half_c;
  logic [31:0] load_res_c;

  assign access_c = EX_MEM_memread | EX_MEM_memwrite;
  assign off_c    = EX_MEM_alures[1:0];

  // Access decode; a store wins when both memread and memwrite are set, and
  // any non-one-hot control falls back to a word access.
  always_comb begin
    size_c    = SZ_W;
    sign_c    = 1'b0;
    be_c      = 4'b1111;
    wdata_c   = EX_MEM_dout_rs2;
    aligned_c = 1'b1;
    if (EX_MEM_memwrite) begin
      case (EX_MEM_storecntrl)
        3'b001:  size_c = SZ_B;
        3'b010:  size_c = SZ_H;
        default: size_c = SZ_W;
      endcase
    end else begin
      case (EX_MEM_loadcntrl)
        5'b00001: begin size_c = SZ_B; sign_c = 1'b1; end
        5'b00010: begin size_c = SZ_H; sign_c = 1'b1; end
        5'b01000: size_c = SZ_B;
        5'b10000: size_c = SZ_H;
        default:  size_c = SZ_W;
      endcase
    end
    case (size_c)
      SZ_B:    aligned_c = 1'b1;
      SZ_H:    aligned_c = ~off_c[0];
      default: aligned_c = (off_c == 2'b00);
    endcase
    if (EX_MEM_memwrite) begin
      case (size_c)
        SZ_B: begin
          be_c    = 4'b0001 << off_c;
          wdata_c = {4{EX_MEM_dout_rs2[7:0]}};
        end
        SZ_H: begin
          be_c    = 4'b0011 << off_c;
          wdata_c = {2{EX_MEM_dout_rs2[15:0]}};
        end
        default: begin
          be_c    = 4'b1111;
          wdata_c = EX_MEM_dout_rs2;
        end
      endcase
    end
  end

  // Load data extraction from the captured read word
  always_comb begin
    case (off_q)
      2'd0:    byte_c = rdata_q[7:0];
      2'd1:    byte_c = rdata_q[15:8];
      2'd2:    byte_c = rdata_q[23:16];
      default: byte_c = rdata_q[31:24];
    endcase
    half_c = off_q[1] ? rdata_q[31:16] : rdata_q[15:0];
    case (size_q)
      SZ_B:    load_res_c = sign_q ? {{24{byte_c[7]}}, byte_c} : {24'd0, byte_c};
      SZ_H:    load_res_c = sign_q ? {{16{half_c[15]}}, half_c} : {16'd0, half_c};
      default: load_res_c = rdata_q;
    endcase
  end

  // Stall must be seen in the same cycle the access is presented
  assign mem_stall = ~Rst & ((state == IDLE & ~debug & access_c & aligned_c) |
                             (state == BUSY) |
                             (state == DONE & debug));

  // Control FSM with registered memory interface and writeback outputs
  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      state           <= IDLE;
      dmem_req        <= 1'b0;
      dmem_we         <= 1'b0;
      dmem_addr       <= '0;
      dmem_be         <= 4'b0000;
      dmem_wdata      <= 32'd0;
      mem_misalign    <= 1'b0;
      MEM_WB_regwrite <= 1'b0;
      MEM_WB_rd       <= 5'd0;
      MEM_WB_res      <= 32'd0;
      load_q          <= 1'b0;
      regwrite_q      <= 1'b0;
      rd_q            <= 5'd0;
      size_q          <= SZ_W;
      sign_q          <= 1'b0;
      off_q           <= 2'd0;
      rdata_q         <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (!debug) begin
            if (access_c && aligned_c) begin
              state           <= BUSY;
              dmem_req        <= 1'b1;
              dmem_we         <= EX_MEM_memwrite;
              dmem_addr       <= {EX_MEM_alures[DMEM_AW-1:2], 2'b00};
              dmem_be         <= be_c;
              dmem_wdata      <= wdata_c;
              load_q          <= EX_MEM_memread & ~EX_MEM_memwrite;
              regwrite_q      <= EX_MEM_regwrite;
              rd_q            <= EX_MEM_rd;
              size_q          <= size_c;
              sign_q          <= sign_c;
              off_q           <= off_c;
              MEM_WB_regwrite <= 1'b0;
            end else if (access_c) begin
              mem_misalign    <= 1'b1;
              MEM_WB_regwrite <= 1'b0;
            end else begin
              MEM_WB_regwrite <= EX_MEM_regwrite;
              MEM_WB_rd       <= EX_MEM_rd;
              MEM_WB_res      <= EX_MEM_alures;
            end
          end
        end
        BUSY: begin
          MEM_WB_regwrite <= 1'b0;
          if (dmem_ack) begin
            rdata_q  <= dmem_rdata;
            dmem_req <= 1'b0;
            state    <= DONE;
          end
        end
        DONE: begin
          if (!debug) begin
            MEM_WB_res      <= load_q ? load_res_c : 32'd0;
            MEM_WB_rd       <= rd_q;
            MEM_WB_regwrite <= regwrite_q & load_q;
            state           <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
